// File: rtl/if_de_pkg.sv
// Shared defaults, entry type and pointer-wrap helper for the fetch->decode queue.
package if_de_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] instr;
    logic [XLEN_DEFAULT-1:0] pc_4;
  } fetch_entry_t;

  // Explicit compare so non-power-of-two depths wrap correctly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/if_de_instr_queue_if.sv
// Fetch/icache/decode signal bundle around the instruction queue.
interface if_de_instr_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            f_req_valid;
  logic            f_req_ready;
  logic [XLEN-1:0] f_pc_4;
  logic            icache_stall;
  logic [XLEN-1:0] icache_dout;
  logic            flush;
  logic            d_valid;
  logic            d_ready;
  logic [XLEN-1:0] d_instr;
  logic [XLEN-1:0] d_pc_4;
  logic [CW-1:0]   occupancy;

  modport master (
    output f_req_valid, f_pc_4, icache_stall, icache_dout, flush, d_ready,
    input  f_req_ready, d_valid, d_instr, d_pc_4, occupancy
  );

  modport slave (
    input  f_req_valid, f_pc_4, icache_stall, icache_dout, flush, d_ready,
    output f_req_ready, d_valid, d_instr, d_pc_4, occupancy
  );
endinterface

// File: rtl/if_de_entry_ram.sv
// Queue storage: one write port, one asynchronous read port, flops without reset.
module if_de_entry_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_de_instr_queue.sv
// Fetch->decode instruction queue: DEPTH entries of {instr, pc_4} plus one
// outstanding icache read; flush overrides every other state update.
module if_de_instr_queue
  import if_de_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input logic clk,
  input logic reset_n,
  if_de_instr_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]     count;
  logic              pending;
  logic [XLEN-1:0]   pend_pc_4;
  logic [CW:0]       used;
  logic              accept, resp, wr_en, pop;
  logic [2*XLEN-1:0] wdata, rdata;

  // Credit counts the in-flight read so a response always has a free slot.
  assign used            = {1'b0, count} + {{CW{1'b0}}, pending};
  assign bus.f_req_ready = (used < (CW+1)'(DEPTH));

  assign accept = bus.f_req_valid & bus.f_req_ready;
  assign resp   = pending & ~bus.icache_stall;
  assign wr_en  = resp & ~bus.flush;
  assign pop    = bus.d_valid & bus.d_ready & ~bus.flush;

  assign wr_ptr_nxt = PW'(ptr_inc(32'(wr_ptr), DEPTH));
  assign rd_ptr_nxt = PW'(ptr_inc(32'(rd_ptr), DEPTH));
  assign wdata      = {bus.icache_dout, pend_pc_4};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= 1'b0;
      pend_pc_4 <= '0;
    end else if (bus.flush) begin
      // A request accepted alongside the flush is the redirect target.
      count   <= '0;
      rd_ptr  <= wr_ptr;
      pending <= accept;
      if (accept) pend_pc_4 <= bus.f_pc_4;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr_nxt;
      if (pop)   rd_ptr <= rd_ptr_nxt;
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept) begin
        pending   <= 1'b1;
        pend_pc_4 <= bus.f_pc_4;
      end else if (resp) begin
        pending <= 1'b0;
      end
    end
  end

  if_de_entry_ram #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.d_valid   = (count != '0);
  assign bus.d_instr   = bus.d_valid ? rdata[2*XLEN-1:XLEN] : NOP_INSTR;
  assign bus.d_pc_4    = bus.d_valid ? rdata[XLEN-1:0] : '0;
  assign bus.occupancy = count;

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    count <= CW'(DEPTH));
  a_nop_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
    !bus.d_valid |-> (bus.d_instr == NOP_INSTR));
  a_no_write_full: assert property (@(posedge clk) disable iff (!reset_n)
    wr_en |-> (count != CW'(DEPTH)));

endmodule

// File: tb/tb_if_de_instr_queue.sv
// Bench for if_de_instr_queue: DEPTH=2 and DEPTH=3 instances checked every cycle
// against a queue-level reference model, plus directed scenarios with literal values.
module tb_if_de_instr_queue;
  import if_de_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        rv   [2];
  logic [31:0] pc   [2];
  logic        st   [2];
  logic [31:0] dout [2];
  logic        fl   [2];
  logic        dr   [2];

  int checks = 0;
  int failures = 0;

  if_de_instr_queue_if #(.XLEN(32), .DEPTH(2)) b2 ();
  if_de_instr_queue_if #(.XLEN(32), .DEPTH(3)) b3 ();

  assign b2.f_req_valid  = rv[0];
  assign b2.f_pc_4       = pc[0];
  assign b2.icache_stall = st[0];
  assign b2.icache_dout  = dout[0];
  assign b2.flush        = fl[0];
  assign b2.d_ready      = dr[0];
  assign b3.f_req_valid  = rv[1];
  assign b3.f_pc_4       = pc[1];
  assign b3.icache_stall = st[1];
  assign b3.icache_dout  = dout[1];
  assign b3.flush        = fl[1];
  assign b3.d_ready      = dr[1];

  if_de_instr_queue #(.XLEN(32), .DEPTH(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  if_de_instr_queue #(.XLEN(32), .DEPTH(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3));

  // ---------------- reference model: a plain queue per instance ----------------
  fetch_entry_t mq0[$];
  fetch_entry_t mq1[$];
  bit           m_pend [2];
  logic [31:0]  m_ppc  [2];

  function automatic int m_depth(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int m_size(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic fetch_entry_t m_front(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic m_push(input int k, input fetch_entry_t e);
    if (k == 0) mq0.push_back(e); else mq1.push_back(e);
  endtask

  task automatic m_pop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic m_clear(input int k);
    if (k == 0) mq0.delete(); else mq1.delete();
  endtask

  task automatic m_step(input int k);
    int sz;
    bit acc, rsp;
    sz  = m_size(k);
    acc = rv[k] && ((sz + int'(m_pend[k])) < m_depth(k));
    rsp = m_pend[k] && !st[k];
    if (fl[k]) begin
      m_clear(k);
      m_pend[k] = acc;
      if (acc) m_ppc[k] = pc[k];
    end else begin
      if (sz > 0 && dr[k]) m_pop(k);
      if (rsp) m_push(k, '{instr: dout[k], pc_4: m_ppc[k]});
      if (acc) begin
        m_pend[k] = 1'b1;
        m_ppc[k]  = pc[k];
      end else if (rsp) begin
        m_pend[k] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_clear(k);
        m_pend[k] = 1'b0;
        m_ppc[k]  = 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic vld,
                     input logic [31:0] ins, input logic [31:0] pc4, input logic [31:0] occ);
    int sz;
    fetch_entry_t h;
    sz = m_size(k);
    h  = (sz > 0) ? m_front(k) : '{instr: 32'h13, pc_4: 32'h0};
    chk($sformatf("k%0d_f_req_ready", k), {31'd0, rdy},
        ((sz + int'(m_pend[k])) < m_depth(k)) ? 32'd1 : 32'd0);
    chk($sformatf("k%0d_d_valid", k), {31'd0, vld}, (sz > 0) ? 32'd1 : 32'd0);
    chk($sformatf("k%0d_d_instr", k), ins, h.instr);
    chk($sformatf("k%0d_d_pc_4", k), pc4, h.pc_4);
    chk($sformatf("k%0d_occupancy", k), occ, 32'(sz));
  endtask

  always @(negedge clk) begin
    cmp(0, b2.f_req_ready, b2.d_valid, b2.d_instr, b2.d_pc_4, 32'(b2.occupancy));
    cmp(1, b3.f_req_ready, b3.d_valid, b3.d_instr, b3.d_pc_4, 32'(b3.occupancy));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; pc[k] = 32'h0; st[k] = 1'b0;
      fl[k] = 1'b0; dr[k] = 1'b0; dout[k] = $urandom;
    end
  endtask

  task automatic settle(input int k);
    rv[k] = 1'b0; st[k] = 1'b0; fl[k] = 1'b0; dr[k] = 1'b1;
    repeat (5) tick();
    dr[k] = 1'b0;
  endtask

  int got[$];
  int sent;
  int cyc;
  bit acc6;

  initial begin
    reset_n = 1'b1;
    idle_all();
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // reset values
    chk("rst_d_valid",   {31'd0, b2.d_valid}, 32'd0);
    chk("rst_d_instr",   b2.d_instr, 32'h0000_0013);
    chk("rst_d_pc_4",    b2.d_pc_4, 32'd0);
    chk("rst_occupancy", 32'(b2.occupancy), 32'd0);
    chk("rst_ready",     {31'd0, b2.f_req_ready}, 32'd1);

    // 1: async reset mid-traffic on DEPTH=3 (count=2, pending=1)
    rv[1] = 1'b1; pc[1] = 32'h100; tick();
    pc[1] = 32'h200; tick();
    pc[1] = 32'h300; tick();
    chk("t1_pre_occ",   32'(b3.occupancy), 32'd2);
    chk("t1_pre_ready", {31'd0, b3.f_req_ready}, 32'd0);
    rv[1] = 1'b0; st[1] = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_d_valid", {31'd0, b3.d_valid}, 32'd0);
    chk("t1_d_instr", b3.d_instr, 32'h0000_0013);
    chk("t1_ready",   {31'd0, b3.f_req_ready}, 32'd1);
    chk("t1_occ",     32'(b3.occupancy), 32'd0);
    tick();
    reset_n = 1'b1;
    idle_all();

    // 2: streaming on DEPTH=2 with decode always ready
    dr[0] = 1'b1;
    rv[0] = 1'b1; pc[0] = 32'd4; tick();
    pc[0] = 32'd8; tick();
    chk("t2_pc_a", b2.d_pc_4, 32'd4);
    chk("t2_ready_nocredit", {31'd0, b2.f_req_ready}, 32'd0);
    pc[0] = 32'd12; tick();
    chk("t2_pc_b", b2.d_pc_4, 32'd8);
    tick();
    chk("t2_empty", {31'd0, b2.d_valid}, 32'd0);
    rv[0] = 1'b0; tick();
    chk("t2_pc_c", b2.d_pc_4, 32'd12);
    settle(0);

    // 3: backpressure on DEPTH=2
    dr[0] = 1'b0;
    rv[0] = 1'b1; pc[0] = 32'h10; tick();
    pc[0] = 32'h20; tick();
    chk("t3_ready_a", {31'd0, b2.f_req_ready}, 32'd0);
    pc[0] = 32'h30; tick();
    chk("t3_occ_full", 32'(b2.occupancy), 32'd2);
    tick();
    chk("t3_head_a", b2.d_pc_4, 32'h10);
    dr[0] = 1'b1; tick();
    chk("t3_head_b", b2.d_pc_4, 32'h20);
    tick();
    rv[0] = 1'b0; tick();
    chk("t3_head_c", b2.d_pc_4, 32'h30);
    settle(0);

    // 4: icache stall held 3 cycles with pending pc_4=0x40
    rv[0] = 1'b1; pc[0] = 32'h40; tick();
    rv[0] = 1'b0; st[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("t4_stall_occ", 32'(b2.occupancy), 32'd0);
    end
    st[0] = 1'b0; dout[0] = 32'hCAFE_0001; tick();
    chk("t4_occ",   32'(b2.occupancy), 32'd1);
    chk("t4_pc",    b2.d_pc_4, 32'h40);
    chk("t4_instr", b2.d_instr, 32'hCAFE_0001);
    dout[0] = 32'h5555_AAAA;
    repeat (2) begin
      tick();
      chk("t4_no_dup", 32'(b2.occupancy), 32'd1);
    end
    settle(0);

    // 5: flush on DEPTH=3 with a response arriving and a redirect request
    rv[1] = 1'b1; pc[1] = 32'h100; tick();
    pc[1] = 32'h200; tick();
    fl[1] = 1'b1; pc[1] = 32'h104; dout[1] = 32'hBAD0_0000; tick();
    chk("t5_occ",     32'(b3.occupancy), 32'd0);
    chk("t5_d_valid", {31'd0, b3.d_valid}, 32'd0);
    fl[1] = 1'b0; rv[1] = 1'b0; dout[1] = 32'h1234_5678; tick();
    chk("t5_pc",    b3.d_pc_4, 32'h104);
    chk("t5_instr", b3.d_instr, 32'h1234_5678);
    settle(1);

    // 6: DEPTH=3 streaming through pointer wrap
    sent = 0; cyc = 0;
    dr[1] = 1'b1;
    while ((sent < 10 || m_size(1) > 0 || m_pend[1]) && cyc < 200) begin
      rv[1]   = (sent < 10);
      pc[1]   = 32'h1000 + 32'(4 * sent);
      dout[1] = $urandom;
      if (b3.d_valid && dr[1]) got.push_back(int'(b3.d_pc_4));
      acc6 = rv[1] && ((m_size(1) + int'(m_pend[1])) < 3);
      tick();
      cyc++;
      if (acc6) sent++;
    end
    chk("t6_in_budget", (cyc < 200) ? 32'd1 : 32'd0, 32'd1);
    chk("t6_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++)
      chk("t6_seq", 32'(got[i]), 32'h1000 + 32'(4 * i));
    settle(1);

    // random traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rv[k]   = ($urandom_range(0, 99) < 65);
        pc[k]   = $urandom & 32'hFFFF_FFFC;
        st[k]   = ($urandom_range(0, 99) < 25);
        dout[k] = $urandom;
        fl[k]   = ($urandom_range(0, 99) < 3);
        dr[k]   = ($urandom_range(0, 99) < ((c < 2000) ? 60 : 30));
      end
      tick();
    end
    idle_all();
    settle(0);
    settle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
